// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default field widths, the ID/EXE bundle layout
// and a helper that returns the bundle width for arbitrary field widths.
package pipe_pkg;

   localparam int unsigned DataW = 32;
   localparam int unsigned RegW  = 5;
   localparam int unsigned ExeW  = 3;
   localparam int unsigned MW    = 1;
   localparam int unsigned WbW   = 2;

   // Bundle order, MSB first: {WB, M, EXE, signEx, PC, readData1, readData2, src1, src2}
   typedef struct packed {
      logic [WbW-1:0]   wb;
      logic [MW-1:0]    m;
      logic [ExeW-1:0]  exe;
      logic [DataW-1:0] sign_ex;
      logic [DataW-1:0] pc;
      logic [DataW-1:0] read_data1;
      logic [DataW-1:0] read_data2;
      logic [RegW-1:0]  src1;
      logic [RegW-1:0]  src2;
   } id_exe_t;

   localparam int unsigned IdExeW = $bits(id_exe_t);

   function automatic int unsigned id_exe_w(input int unsigned data_w, input int unsigned reg_w,
                                            input int unsigned exe_w, input int unsigned m_w,
                                            input int unsigned wb_w);
      return wb_w + m_w + exe_w + 4 * data_w + 2 * reg_w;
   endfunction

endpackage

// File: rtl/elastic_skid_reg.sv
// Generic valid/ready pipeline register with a one-entry skid buffer.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous kill of both entries; same-cycle accept dropped
//   valid_i/ready_o   upstream handshake (ready_o registered, = !skid valid)
//   data_i            upstream payload
//   valid_o/ready_i   downstream handshake (valid_o = main valid)
//   data_o            main entry payload
//   occupancy_o       number of held entries, 0..2
module elastic_skid_reg #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] data_o,
   output logic [1:0]       occupancy_o
);

   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             ready_q, ready_d;
   logic [Width-1:0] main_data_q, main_data_d;
   logic [Width-1:0] skid_data_q, skid_data_d;
   logic             accept, release_w;

   assign accept    = valid_i & ready_q;
   assign release_w = main_valid_q & ready_i;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         // Data registers are left untouched so outputs do not toggle in a bubble.
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = data_i;
         end
      end else if (!skid_valid_q) begin
         if (accept && release_w) begin
            main_data_d = data_i;
         end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = data_i;
         end else if (release_w) begin
            main_valid_d = 1'b0;
         end
      end else if (release_w) begin
         // Full: ready_o is low, so only a drain from skid into main can happen.
         main_data_d  = skid_data_q;
         skid_valid_d = 1'b0;
      end
      ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign ready_o     = ready_q;
   assign valid_o     = main_valid_q;
   assign data_o      = main_data_q;
   assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

   a_skid_implies_main : assert property (@(posedge clk) disable iff (rst)
      skid_valid_q |-> main_valid_q);
   a_ready_is_not_skid : assert property (@(posedge clk) disable iff (rst)
      ready_q == ~skid_valid_q);
   a_stall_stable : assert property (@(posedge clk) disable iff (rst)
      (valid_o && !ready_i) |=> $stable(data_o));

endmodule

// File: rtl/id2exe_elastic_reg.sv
// ID->EXE flow-controlled pipeline register. Packs the decode fields into one
// bundle, passes it through a skid register, and zeroes the EXE/M/WB control
// outputs whenever the stage holds a bubble.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     kill held entries (taken branch/jump)
//   validIn/readyOut          ID-side handshake
//   *In                       ID data and control fields
//   validOut/readyIn          EXE-side handshake
//   *Out                      EXE-side fields (control zero when !validOut)
//   occupancy                 held entries, 0..2
module id2exe_elastic_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DataW,
   parameter int unsigned REG_W  = RegW,
   parameter int unsigned EXE_W  = ExeW,
   parameter int unsigned M_W    = MW,
   parameter int unsigned WB_W   = WbW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              validIn,
   output logic              readyOut,
   input  logic [DATA_W-1:0] signExIn,
   input  logic [DATA_W-1:0] PC_In,
   input  logic [DATA_W-1:0] readData1In,
   input  logic [DATA_W-1:0] readData2In,
   input  logic [EXE_W-1:0]  EXE_In,
   input  logic [M_W-1:0]    M_In,
   input  logic [WB_W-1:0]   WB_In,
   input  logic [REG_W-1:0]  src1In,
   input  logic [REG_W-1:0]  src2In,
   output logic              validOut,
   input  logic              readyIn,
   output logic [DATA_W-1:0] signExOut,
   output logic [DATA_W-1:0] PC_Out,
   output logic [DATA_W-1:0] readData1Out,
   output logic [DATA_W-1:0] readData2Out,
   output logic [EXE_W-1:0]  EXE_Out,
   output logic [M_W-1:0]    M_Out,
   output logic [WB_W-1:0]   WB_Out,
   output logic [REG_W-1:0]  src1Out,
   output logic [REG_W-1:0]  src2Out,
   output logic [1:0]        occupancy
);

   // Same layout as pipe_pkg::id_exe_t, but sized by this instance's parameters.
   typedef struct packed {
      logic [WB_W-1:0]   wb;
      logic [M_W-1:0]    m;
      logic [EXE_W-1:0]  exe;
      logic [DATA_W-1:0] sign_ex;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] read_data1;
      logic [DATA_W-1:0] read_data2;
      logic [REG_W-1:0]  src1;
      logic [REG_W-1:0]  src2;
   } bundle_t;

   localparam int unsigned BundleW = id_exe_w(DATA_W, REG_W, EXE_W, M_W, WB_W);

   bundle_t in_b;
   bundle_t out_b;
   logic    main_valid;

   always_comb begin
      in_b            = '0;
      in_b.wb         = WB_In;
      in_b.m          = M_In;
      in_b.exe        = EXE_In;
      in_b.sign_ex    = signExIn;
      in_b.pc         = PC_In;
      in_b.read_data1 = readData1In;
      in_b.read_data2 = readData2In;
      in_b.src1       = src1In;
      in_b.src2       = src2In;
   end

   elastic_skid_reg #(
      .Width(BundleW)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .valid_i    (validIn),
      .ready_o    (readyOut),
      .data_i     (in_b),
      .valid_o    (main_valid),
      .ready_i    (readyIn),
      .data_o     (out_b),
      .occupancy_o(occupancy)
   );

   // Gating uses the registered valid bit only, so flush never reaches these
   // outputs combinationally.
   always_comb begin
      validOut     = main_valid;
      EXE_Out      = main_valid ? out_b.exe : '0;
      M_Out        = main_valid ? out_b.m : '0;
      WB_Out       = main_valid ? out_b.wb : '0;
      signExOut    = out_b.sign_ex;
      PC_Out       = out_b.pc;
      readData1Out = out_b.read_data1;
      readData2Out = out_b.read_data2;
      src1Out      = out_b.src1;
      src2Out      = out_b.src2;
   end

endmodule

// File: tb/tb_id2exe_elastic_reg.sv
module tb_id2exe_elastic_reg;

   typedef struct packed {
      logic [1:0]  wb;
      logic [0:0]  m;
      logic [2:0]  exe;
      logic [31:0] sign_ex;
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [4:0]  src1;
      logic [4:0]  src2;
   } instr_t;

   logic clk = 1'b0;
   logic rst;
   logic flush, valid_in, ready_in;
   instr_t stim;

   logic        ready_out, valid_out;
   logic [31:0] sign_ex_out, pc_out, rd1_out, rd2_out;
   logic [2:0]  exe_out;
   logic [0:0]  m_out;
   logic [1:0]  wb_out;
   logic [4:0]  src1_out, src2_out;
   logic [1:0]  occ;

   // Wide instance signals
   logic        w_valid_in, w_ready_in, w_flush;
   logic [63:0] w_sign_in, w_pc_in, w_rd1_in, w_rd2_in;
   logic [2:0]  w_exe_in;
   logic [0:0]  w_m_in;
   logic [1:0]  w_wb_in;
   logic [5:0]  w_src1_in, w_src2_in;
   logic        w_ready_out, w_valid_out;
   logic [63:0] w_sign_out, w_pc_out, w_rd1_out, w_rd2_out;
   logic [2:0]  w_exe_out;
   logic [0:0]  w_m_out;
   logic [1:0]  w_wb_out;
   logic [5:0]  w_src1_out, w_src2_out;
   logic [1:0]  w_occ;

   int n_checks = 0;
   int n_fail   = 0;

   instr_t q[$];
   instr_t last;

   always #5 clk = ~clk;

   id2exe_elastic_reg dut (
      .clk(clk), .rst(rst), .flush(flush), .validIn(valid_in), .readyOut(ready_out),
      .signExIn(stim.sign_ex), .PC_In(stim.pc), .readData1In(stim.rd1),
      .readData2In(stim.rd2), .EXE_In(stim.exe), .M_In(stim.m), .WB_In(stim.wb),
      .src1In(stim.src1), .src2In(stim.src2), .validOut(valid_out), .readyIn(ready_in),
      .signExOut(sign_ex_out), .PC_Out(pc_out), .readData1Out(rd1_out),
      .readData2Out(rd2_out), .EXE_Out(exe_out), .M_Out(m_out), .WB_Out(wb_out),
      .src1Out(src1_out), .src2Out(src2_out), .occupancy(occ)
   );

   id2exe_elastic_reg #(
      .DATA_W(64),
      .REG_W (6)
   ) dut_wide (
      .clk(clk), .rst(rst), .flush(w_flush), .validIn(w_valid_in), .readyOut(w_ready_out),
      .signExIn(w_sign_in), .PC_In(w_pc_in), .readData1In(w_rd1_in),
      .readData2In(w_rd2_in), .EXE_In(w_exe_in), .M_In(w_m_in), .WB_In(w_wb_in),
      .src1In(w_src1_in), .src2In(w_src2_in), .validOut(w_valid_out), .readyIn(w_ready_in),
      .signExOut(w_sign_out), .PC_Out(w_pc_out), .readData1Out(w_rd1_out),
      .readData2Out(w_rd2_out), .EXE_Out(w_exe_out), .M_Out(w_m_out), .WB_Out(w_wb_out),
      .src1Out(w_src1_out), .src2Out(w_src2_out), .occupancy(w_occ)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic instr_t rand_instr();
      instr_t r;
      r.wb      = 2'($urandom);
      r.m       = 1'($urandom);
      r.exe     = 3'($urandom);
      r.sign_ex = $urandom;
      r.pc      = $urandom;
      r.rd1     = $urandom;
      r.rd2     = $urandom;
      r.src1    = 5'($urandom);
      r.src2    = 5'($urandom);
      return r;
   endfunction

   // Reference: a FIFO of capacity two, read one cycle after it is written.
   task automatic model_step();
      bit acc, rel;
      acc = valid_in && (q.size() < 2);
      rel = (q.size() > 0) && ready_in;
      if (flush) begin
         q.delete();
      end else begin
         if (rel) void'(q.pop_front());
         if (acc) q.push_back(stim);
      end
      if (q.size() > 0) last = q[0];
   endtask

   task automatic check_all(input string tag);
      bit full;
      full = q.size() > 0;
      check_eq({tag, ".valid"}, valid_out, full);
      check_eq({tag, ".ready"}, ready_out, q.size() < 2);
      check_eq({tag, ".occ"}, occ, q.size());
      check_eq({tag, ".pc"}, pc_out, last.pc);
      check_eq({tag, ".sign"}, sign_ex_out, last.sign_ex);
      check_eq({tag, ".rd1"}, rd1_out, last.rd1);
      check_eq({tag, ".rd2"}, rd2_out, last.rd2);
      check_eq({tag, ".src1"}, src1_out, last.src1);
      check_eq({tag, ".src2"}, src2_out, last.src2);
      check_eq({tag, ".exe"}, exe_out, full ? last.exe : 3'd0);
      check_eq({tag, ".m"}, m_out, full ? last.m : 1'b0);
      check_eq({tag, ".wb"}, wb_out, full ? last.wb : 2'd0);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic send(input logic [31:0] pc, input bit v, input bit rdy, input bit fl);
      stim     = rand_instr();
      stim.pc  = pc;
      valid_in = v;
      ready_in = rdy;
      flush    = fl;
   endtask

   initial begin
      rst        = 1'b1;
      flush      = 1'b0;
      valid_in   = 1'b0;
      ready_in   = 1'b0;
      stim       = '0;
      last       = '0;
      w_flush    = 1'b0;
      w_valid_in = 1'b0;
      w_ready_in = 1'b0;
      w_sign_in  = 64'h1111_2222_3333_4444;
      w_pc_in    = 64'h5555_6666_7777_8888;
      w_rd1_in   = 64'hDEAD_BEEF_0123_4567;
      w_rd2_in   = 64'h9999_AAAA_BBBB_CCCC;
      w_exe_in   = 3'h5;
      w_m_in     = 1'b1;
      w_wb_in    = 2'h2;
      w_src1_in  = 6'h3F;
      w_src2_in  = 6'h15;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_all("post_reset");

      // Wide parameter pass-through
      w_valid_in = 1'b1;
      tick("wide_idle");
      w_valid_in = 1'b0;
      check_eq("wide.valid", w_valid_out, 1'b1);
      check_eq("wide.rd1", w_rd1_out, 64'hDEAD_BEEF_0123_4567);
      check_eq("wide.src1", w_src1_out, 6'h3F);
      check_eq("wide.src2", w_src2_out, 6'h15);
      check_eq("wide.pc", w_pc_out, 64'h5555_6666_7777_8888);
      check_eq("wide.sign", w_sign_out, 64'h1111_2222_3333_4444);
      check_eq("wide.rd2", w_rd2_out, 64'h9999_AAAA_BBBB_CCCC);
      check_eq("wide.ctl", {w_wb_out, w_m_out, w_exe_out}, {2'h2, 1'b1, 3'h5});
      w_ready_in = 1'b1;
      tick("wide_drain");
      check_eq("wide.bubble_valid", w_valid_out, 1'b0);
      check_eq("wide.bubble_exe", w_exe_out, 3'd0);
      check_eq("wide.hold_rd1", w_rd1_out, 64'hDEAD_BEEF_0123_4567);

      // Streaming at full throughput
      for (int i = 0; i < 3; i++) begin
         send(32'(i * 4), 1'b1, 1'b1, 1'b0);
         tick("stream");
         check_eq("stream.pc_order", pc_out, 32'(i * 4));
      end
      send(32'h0, 1'b0, 1'b1, 1'b0);
      tick("stream_drain");

      // Stall fills the skid, then drains in order
      send(32'h10, 1'b1, 1'b0, 1'b0);
      tick("stall0");
      send(32'h14, 1'b1, 1'b0, 1'b0);
      tick("stall1");
      check_eq("stall.occ2", occ, 2'd2);
      check_eq("stall.ready0", ready_out, 1'b0);
      check_eq("stall.pc_head", pc_out, 32'h10);
      send(32'h0, 1'b0, 1'b1, 1'b0);
      tick("drain0");
      check_eq("drain.pc_second", pc_out, 32'h14);
      check_eq("drain.ready1", ready_out, 1'b1);
      tick("drain1");

      // Flush while full, with a competing input that must be dropped
      send(32'h30, 1'b1, 1'b0, 1'b0);
      tick("fill0");
      send(32'h34, 1'b1, 1'b0, 1'b0);
      tick("fill1");
      send(32'h18, 1'b1, 1'b0, 1'b1);
      tick("flush");
      check_eq("flush.valid", valid_out, 1'b0);
      check_eq("flush.ctl", {wb_out, m_out, exe_out}, 6'd0);
      check_eq("flush.occ", occ, 2'd0);
      check_eq("flush.ready", ready_out, 1'b1);
      send(32'h0, 1'b0, 1'b1, 1'b0);
      tick("post_flush");
      check_eq("flush.no_0x18", valid_out, 1'b0);

      // Simultaneous accept and release in ONE
      send(32'h20, 1'b1, 1'b0, 1'b0);
      tick("one");
      send(32'h24, 1'b1, 1'b1, 1'b0);
      tick("acc_rel");
      check_eq("acc_rel.pc", pc_out, 32'h24);
      check_eq("acc_rel.occ", occ, 2'd1);

      // Async reset while ONE holds PC=0x40
      send(32'h0, 1'b0, 1'b1, 1'b0);
      tick("pre_rst_drain");
      send(32'h40, 1'b1, 1'b0, 1'b0);
      tick("rst_load");
      check_eq("rst_load.pc", pc_out, 32'h40);
      send(32'h0, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      q.delete();
      last = '0;
      check_all("async_rst");
      check_eq("async_rst.pc", pc_out, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all("rst_release");

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         stim     = rand_instr();
         valid_in = ($urandom_range(0, 9) < 7);
         ready_in = ($urandom_range(0, 9) < 6);
         flush    = ($urandom_range(0, 19) == 0);
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
